misaligned_load_unit: RTL and testbench

Load-data unit for the core's MEM stage: accepts a load (address + `memop`), fetches one or two naturally aligned memory words, merges them, and returns the byte/half/word/double extracted and sign- or zero-extended. It generalises plain single-word load extraction in three ways:
- data width is parametrised;
- loads that straddle a word boundary are split into two accesses;
- request, memory and response sides all use valid/ready handshakes.

---
 rtl/misaligned_load_unit.sv | 179 +++++++++++++++++
 tb/tb_misaligned_load_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misaligned_load_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | misaligned_load_unit                                                |
// | MEM-stage load extractor; splits word-straddling loads into two     |
// | aligned reads and returns the sign/zero-extended result.            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module misaligned_load_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_memop,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_split,
    output logic              resp_err
);
    localparam int c_NB    = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);

    localparam logic [2:0] c_MEM_B  = 3'd0;
    localparam logic [2:0] c_MEM_H  = 3'd1;
    localparam logic [2:0] c_MEM_W  = 3'd2;
    localparam logic [2:0] c_MEM_D  = 3'd3;
    localparam logic [2:0] c_MEM_UB = 3'd4;
    localparam logic [2:0] c_MEM_UH = 3'd5;
    localparam logic [2:0] c_MEM_UW = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [2:0]          r_memop;
    logic [c_OFF_W-1:0]  r_off;
    logic                r_split;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_split;
    logic                r_resp_err;

    logic [c_OFF_W-1:0]  w_req_off;
    logic [3:0]          w_req_size;
    logic                w_req_err;
    logic                w_req_split;
    logic [ADDR_W-1:0]   w_req_aligned;
    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic [2*DATA_W-1:0] w_cat;
    logic [DATA_W-1:0]   w_t;
    logic [DATA_W-1:0]   w_ext;

    always_comb begin
        w_req_size = 4'd0;
        case (req_memop)
            c_MEM_B, c_MEM_UB: w_req_size = 4'd1;
            c_MEM_H, c_MEM_UH: w_req_size = 4'd2;
            c_MEM_W, c_MEM_UW: w_req_size = 4'd4;
            c_MEM_D:           w_req_size = 4'd8;
            default:           w_req_size = 4'd0;
        endcase
    end

    assign w_req_off     = req_addr[c_OFF_W-1:0];
    assign w_req_aligned = {req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
    assign w_req_err     = (w_req_size == 4'd0) || ((req_memop == c_MEM_D) && (DATA_W != 64));
    assign w_req_split   = !w_req_err && ((int'(w_req_off) + int'(w_req_size)) > c_NB);

    // The word arriving this cycle is merged directly so the result can be registered on the last beat.
    assign w_lo  = (r_state == S_WAIT1) ? r_lo : mem_rdata;
    assign w_hi  = (r_state == S_WAIT1) ? mem_rdata : {DATA_W{1'b0}};
    assign w_cat = {w_hi, w_lo};
    assign w_t   = DATA_W'(w_cat >> {r_off, 3'b000});

    always_comb begin
        w_ext = '0;
        case (r_memop)
            c_MEM_B:  w_ext = DATA_W'($signed(w_t[7:0]));
            c_MEM_H:  w_ext = DATA_W'($signed(w_t[15:0]));
            c_MEM_W:  w_ext = DATA_W'($signed(w_t[31:0]));
            c_MEM_D:  w_ext = w_t;
            c_MEM_UB: w_ext = DATA_W'(w_t[7:0]);
            c_MEM_UH: w_ext = DATA_W'(w_t[15:0]);
            c_MEM_UW: w_ext = DATA_W'(w_t[31:0]);
            default:  w_ext = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)  w_state_nxt = w_req_err ? S_RESP : S_REQ0;
            S_REQ0:  if (mem_gnt)    w_state_nxt = S_WAIT0;
            S_WAIT0: if (mem_rvalid) w_state_nxt = r_split ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_gnt)    w_state_nxt = S_WAIT1;
            S_WAIT1: if (mem_rvalid) w_state_nxt = S_RESP;
            S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_memop      <= '0;
            r_off        <= '0;
            r_split      <= 1'b0;
            r_lo         <= '0;
            r_resp_data  <= '0;
            r_resp_split <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_memop    <= req_memop;
                        r_off      <= w_req_off;
                        r_split    <= w_req_split;
                        r_mem_addr <= w_req_aligned;
                        if (w_req_err) begin
                            r_resp_data  <= '0;
                            r_resp_split <= 1'b0;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        r_lo <= mem_rdata;
                        if (r_split) begin
                            r_mem_addr <= r_mem_addr + ADDR_W'(c_NB);
                        end else begin
                            r_resp_data  <= w_ext;
                            r_resp_split <= 1'b0;
                            r_resp_err   <= 1'b0;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        r_resp_data  <= w_ext;
                        r_resp_split <= 1'b1;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign mem_req    = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign mem_addr   = r_mem_addr;
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_resp_data;
    assign resp_split = r_resp_split;
    assign resp_err   = r_resp_err;
endmodule
`default_nettype wire

// File: tb/tb_misaligned_load_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_misaligned_load_unit                                             |
// | Randomised loads against a byte-level memory reference model.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_misaligned_load_unit;
    localparam logic [2:0] c_MEM_B  = 3'd0;
    localparam logic [2:0] c_MEM_H  = 3'd1;
    localparam logic [2:0] c_MEM_W  = 3'd2;
    localparam logic [2:0] c_MEM_D  = 3'd3;
    localparam logic [2:0] c_MEM_UB = 3'd4;
    localparam logic [2:0] c_MEM_UH = 3'd5;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic [2:0]  req_memop;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_rdata;
    logic        resp_valid, resp_ready, resp_split, resp_err;
    logic [63:0] resp_data;

    logic        req_valid_32, req_ready_32;
    logic [31:0] req_addr_32;
    logic [2:0]  req_memop_32;
    logic        mem_req_32, mem_gnt_32, mem_rvalid_32;
    logic [31:0] mem_addr_32, mem_rdata_32;
    logic        resp_valid_32, resp_ready_32, resp_split_32, resp_err_32;
    logic [31:0] resp_data_32;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem_bytes [logic [63:0]];
    logic [63:0] gnt_log [$];
    logic [63:0] rv_q [$];
    int          rv_cnt, gnt_cnt, n_req_cyc;
    int          gnt_lo, gnt_hi, rv_lo, rv_hi;

    misaligned_load_unit #(.DATA_W(64), .ADDR_W(64)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_memop(req_memop),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_split(resp_split), .resp_err(resp_err)
    );

    misaligned_load_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_32), .req_ready(req_ready_32), .req_addr(req_addr_32), .req_memop(req_memop_32),
        .mem_req(mem_req_32), .mem_gnt(mem_gnt_32), .mem_addr(mem_addr_32),
        .mem_rvalid(mem_rvalid_32), .mem_rdata(mem_rdata_32),
        .resp_valid(resp_valid_32), .resp_ready(resp_ready_32), .resp_data(resp_data_32),
        .resp_split(resp_split_32), .resp_err(resp_err_32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Unwritten bytes read back as a fixed hash of their address.
    function automatic logic [7:0] mb(input logic [63:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[2:0], a[7:3]};
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mb(a + 64'(i));
        return w;
    endfunction

    task automatic set_word(input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < 8; i++) mem_bytes[a + 64'(i)] = w[8*i +: 8];
    endtask

    // Reference: gather `size` little-endian bytes from memory and extend.
    task automatic ref_load(input logic [63:0] a, input logic [2:0] op,
                            output logic [63:0] d, output logic sp, output logic er);
        int size;
        bit sgn;
        size = 0;
        sgn  = 1'b0;
        case (op)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd3: size = 8;
            3'd4: size = 1;
            3'd5: size = 2;
            3'd6: size = 4;
            default: size = 0;
        endcase
        er = (size == 0);
        d  = '0;
        sp = 1'b0;
        if (!er) begin
            for (int i = 0; i < size; i++) d[8*i +: 8] = mb(a + 64'(i));
            if (sgn && d[8*size-1])
                for (int i = size; i < 8; i++) d[8*i +: 8] = 8'hFF;
            sp = (int'(a[2:0]) + size) > 8;
        end
    endtask

    // Memory responder: grants after a random delay, returns data a random number of cycles later.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        gnt_cnt = -1; rv_cnt = 0; n_req_cyc = 0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_q.size() > 0) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word_at(rv_q.pop_front());
                end else begin
                    rv_cnt--;
                end
            end
            if (!rst) begin
                gnt_cnt = -1;
            end else if (mem_req) begin
                n_req_cyc++;
                if (gnt_cnt < 0) gnt_cnt = int'($urandom_range(gnt_hi, gnt_lo));
                if (gnt_cnt == 0) begin
                    mem_gnt = 1'b1;
                    gnt_log.push_back(mem_addr);
                    rv_q.push_back(mem_addr);
                    rv_cnt  = int'($urandom_range(rv_hi, rv_lo));
                    gnt_cnt = -1;
                end else begin
                    gnt_cnt--;
                end
            end
        end
    end

    task automatic do_load(input logic [63:0] a, input logic [2:0] op, input int bp,
                           input bit chk_lat, input int exp_lat, output logic [63:0] obs);
        logic [63:0] ed, al;
        logic        es, ee;
        int          lat, r0;
        ref_load(a, op, ed, es, ee);
        al  = {a[63:3], 3'b000};
        lat = 0;
        while (!req_ready && lat < 100) begin @(negedge clk); lat++; end
        chk_eq("req_ready_idle", req_ready, 1);
        gnt_log.delete();
        r0        = n_req_cyc;
        req_valid = 1'b1;
        req_addr  = a;
        req_memop = op;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        lat = 1;
        while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk_eq("resp_valid", resp_valid, 1);
        if (chk_lat) chk_eq("latency", lat, exp_lat);
        chk_eq("resp_data", resp_data, ed);
        chk_eq("resp_split", resp_split, es);
        chk_eq("resp_err", resp_err, ee);
        chk_eq("req_ready_busy", req_ready, 0);
        if (ee) begin
            chk_eq("err_no_mem_req", n_req_cyc - r0, 0);
        end else begin
            chk_eq("mem_accesses", gnt_log.size(), es ? 2 : 1);
            if (gnt_log.size() > 0) chk_eq("mem_addr0", gnt_log[0], al);
            if (es && gnt_log.size() > 1) chk_eq("mem_addr1", gnt_log[1], al + 64'd8);
        end
        obs = resp_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk_eq("bp_valid", resp_valid, 1);
            chk_eq("bp_data", resp_data, ed);
            chk_eq("bp_split", resp_split, es);
            chk_eq("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_eq("post_hs_valid", resp_valid, 0);
        chk_eq("post_hs_ready", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 2000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] obs, a;
        logic [2:0]  op;
        int          k;
        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_memop = '0; resp_ready = 1'b0;
        req_valid_32 = 1'b0; req_addr_32 = '0; req_memop_32 = '0; resp_ready_32 = 1'b0;
        mem_gnt_32 = 1'b0; mem_rvalid_32 = 1'b0; mem_rdata_32 = '0;
        gnt_lo = 0; gnt_hi = 0; rv_lo = 0; rv_hi = 0;
        repeat (2) @(negedge clk);
        chk_eq("rst_req_ready", req_ready, 1);
        chk_eq("rst_mem_req", mem_req, 0);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_resp_valid", resp_valid, 0);
        chk_eq("rst_resp_data", resp_data, 0);
        chk_eq("rst_resp_split", resp_split, 0);
        chk_eq("rst_resp_err", resp_err, 0);
        chk_eq("rst_req_ready_32", req_ready_32, 1);
        rst = 1'b1;
        @(negedge clk);

        set_word(64'h1000, 64'h8877665544332211);
        do_load(64'h1000, c_MEM_D, 0, 1'b1, 3, obs);
        chk_eq("plan_d_data", obs, 64'h8877665544332211);

        set_word(64'h1000, 64'h0000000080000000);
        do_load(64'h1003, c_MEM_B, 0, 1'b1, 3, obs);
        chk_eq("plan_b_data", obs, 64'hFFFFFFFFFFFFFF80);
        do_load(64'h1003, c_MEM_UB, 0, 1'b1, 3, obs);
        chk_eq("plan_ub_data", obs, 64'h0000000000000080);

        set_word(64'h1000, 64'hBBAA000000000000);
        set_word(64'h1008, 64'h000000000000DDCC);
        do_load(64'h1006, c_MEM_W, 0, 1'b1, 5, obs);
        chk_eq("plan_w_data", obs, 64'hFFFFFFFFDDCCBBAA);
        chk_eq("plan_w_addr1", gnt_log[1], 64'h1008);

        mem_bytes[64'h1007] = 8'hEE;
        mem_bytes[64'h1008] = 8'h11;
        gnt_lo = 2; gnt_hi = 2;
        do_load(64'h1007, c_MEM_UH, 4, 1'b1, 9, obs);
        chk_eq("plan_uh_data", obs, 64'h00000000000011EE);
        gnt_lo = 0; gnt_hi = 0;

        do_load(64'h1010, 3'd7, 2, 1'b1, 1, obs);

        // Reset while the second word of a split load is outstanding.
        rv_lo = 5; rv_hi = 5;
        gnt_log.delete();
        req_valid = 1'b1; req_addr = 64'h1006; req_memop = c_MEM_W;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (gnt_log.size() < 2 && k < 50) begin @(negedge clk); k++; end
        chk_eq("mid_two_grants", gnt_log.size(), 2);
        @(negedge clk);
        chk_eq("mid_no_resp", resp_valid, 0);
        #2 rst = 1'b0;
        #1;
        chk_eq("mid_rst_req_ready", req_ready, 1);
        chk_eq("mid_rst_mem_req", mem_req, 0);
        chk_eq("mid_rst_mem_addr", mem_addr, 0);
        chk_eq("mid_rst_resp_valid", resp_valid, 0);
        chk_eq("mid_rst_resp_data", resp_data, 0);
        chk_eq("mid_rst_resp_split", resp_split, 0);
        chk_eq("mid_rst_resp_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        while (rv_q.size() > 0 && k < 50) begin
            @(negedge clk);
            chk_eq("stray_no_resp", resp_valid, 0);
            k++;
        end
        chk_eq("stray_drained", rv_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk_eq("stray_idle_valid", resp_valid, 0);
            chk_eq("stray_idle_ready", req_ready, 1);
        end
        rv_lo = 0; rv_hi = 0;
        do_load(64'h2000, c_MEM_W, 0, 1'b1, 3, obs);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            else                           a = 64'h1000 + 64'($urandom_range(0, 255));
            op     = 3'($urandom_range(0, 7));
            gnt_hi = int'($urandom_range(0, 3));
            rv_hi  = int'($urandom_range(0, 3));
            do_load(a, op, int'($urandom_range(0, 3)), 1'b0, 0, obs);
        end
        gnt_hi = 0; rv_hi = 0;

        req_valid_32 = 1'b1; req_addr_32 = 32'h100; req_memop_32 = c_MEM_D;
        @(negedge clk);
        req_valid_32 = 1'b0;
        chk_eq("e32_resp_valid", resp_valid_32, 1);
        chk_eq("e32_resp_err", resp_err_32, 1);
        chk_eq("e32_resp_data", resp_data_32, 0);
        chk_eq("e32_mem_req", mem_req_32, 0);
        resp_ready_32 = 1'b1;
        @(negedge clk);
        resp_ready_32 = 1'b0;
        chk_eq("e32_post_hs", resp_valid_32, 0);
        chk_eq("e32_post_mem_req", mem_req_32, 0);

        req_valid_32 = 1'b1; req_addr_32 = 32'h102; req_memop_32 = c_MEM_H;
        @(negedge clk);
        req_valid_32 = 1'b0;
        chk_eq("h32_mem_req", mem_req_32, 1);
        chk_eq("h32_mem_addr", mem_addr_32, 32'h100);
        mem_gnt_32 = 1'b1;
        @(negedge clk);
        mem_gnt_32 = 1'b0;
        mem_rvalid_32 = 1'b1; mem_rdata_32 = 32'h8001_1234;
        @(negedge clk);
        mem_rvalid_32 = 1'b0;
        chk_eq("h32_resp_valid", resp_valid_32, 1);
        chk_eq("h32_resp_data", resp_data_32, 32'hFFFF8001);
        chk_eq("h32_resp_split", resp_split_32, 0);
        chk_eq("h32_resp_err", resp_err_32, 0);
        resp_ready_32 = 1'b1;
        @(negedge clk);
        resp_ready_32 = 1'b0;
        chk_eq("h32_ready_again", req_ready_32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
